udp_csum_sync_fifo: RTL and testbench
=====================================

UDP_CSUM_SYNC_FIFO -- requirements
Module: udp_csum_sync_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: data word width (1..1152).
REQ-002 SHALL have parameter DEPTH_WIDTH, default 8: log2 of depth (4..16); depth = 2**DEPTH_WIDTH.
REQ-003 SHALL have parameter FWFT, default 0: 0 = standard read, 1 = first-word-fall-through.
REQ-004 SHALL have parameter ALMOST_FULL_NUM, default 250: almost_full threshold in words.
REQ-005 SHALL have parameter ALMOST_EMPTY_NUM, default 4: almost_empty threshold in words.
REQ-006 SHALL have port clk  in  1: single clock; all logic on rising edge.
REQ-007 SHALL have port rst  in  1: reset, asynchronous and active-high.
REQ-008 SHALL have ports wr_en in 1 and wr_data in DATA_WIDTH: write request and data.
REQ-009 SHALL have ports wr_full out 1, almost_full out 1, wr_water_level out DEPTH_WIDTH+1.
REQ-010 SHALL have ports rd_en in 1 and rd_data out DATA_WIDTH: read request (pop in FWFT) and data.
REQ-011 SHALL have ports rd_empty out 1, almost_empty out 1, rd_water_level out DEPTH_WIDTH+1.
REQ-012 SHALL have ports overflow out 1, underflow out 1 (sticky), clr_err in 1 (clears both).

Function
REQ-013 Write SHALL be accepted only when wr_en=1 and wr_full=0 at the edge; rejected writes leave storage and level unchanged.
REQ-014 Read SHALL be accepted only when rd_en=1 and rd_empty=0 at the edge; flags are sampled before the edge, so simultaneous write into an empty FIFO never satisfies the same-cycle read.
REQ-015 Simultaneous accepted read and write SHALL leave the level unchanged; write while full SHALL be rejected even if a read is accepted in the same cycle.
REQ-016 Level SHALL be a registered count 0..2**DEPTH_WIDTH; wr_water_level and rd_water_level SHALL both equal it.
REQ-017 wr_full SHALL be 1 iff level = 2**DEPTH_WIDTH; rd_empty (FWFT=0) SHALL be 1 iff level = 0.
REQ-018 almost_full SHALL be 1 iff level >= ALMOST_FULL_NUM; almost_empty SHALL be 1 iff level <= ALMOST_EMPTY_NUM; both combinational from the level register.
REQ-019 Read and write pointers SHALL be DEPTH_WIDTH bits and wrap from 2**DEPTH_WIDTH-1 to 0 without gaps.
REQ-020 FWFT=0: rd_data SHALL present the popped word one cycle after the accepting edge and hold it until the next accepted read.
REQ-021 FWFT=1: rd_data SHALL present the head word whenever rd_empty=0; rd_en pops it and the next word (if any) appears the following cycle without a bubble on back-to-back pops.
REQ-022 FWFT=1: first word written into an empty FIFO SHALL appear on rd_data with rd_empty=0 exactly one cycle after the write edge; level counts the word held on rd_data.
REQ-023 Data SHALL leave in write order with no loss, duplication or corruption across pointer wrap.
REQ-024 overflow SHALL set on any cycle with wr_en=1 and wr_full=1; underflow SHALL set on any cycle with rd_en=1 and rd_empty=1.
REQ-025 clr_err SHALL clear overflow and underflow next edge; a coincident set condition SHALL take priority over clr_err.

Reset
REQ-026 rst=1 SHALL immediately force level=0, pointers=0, rd_data=0, wr_full=0, almost_full=0, rd_empty=1, almost_empty=1, overflow=0, underflow=0.
REQ-027 Reset mid-operation SHALL discard all contents; storage array contents need not be cleared.
REQ-028 First write SHALL be accepted on the first rising edge after rst deasserts.

Structure
REQ-029 Default constants (width, depth, thresholds) SHALL live in the shared udp_csum package/header.
REQ-030 Storage SHALL be a separate sub-module udp_csum_fifo_ram: simple dual-port, one write port, one registered read port, inferable as DRM.
REQ-031 Pointer, level, flag and FWFT prefetch logic SHALL be in udp_csum_sync_fifo; no other sub-modules.

Verification
REQ-032 Defaults, FWFT=0: write 256 words FFFFFFFF downward -> wr_full=1 after 256th, level=256, almost_full=1 from level 250; read 256 -> FFFFFFFF..FFFFFF00 in order, rd_empty=1, level=0.
REQ-033 Full FIFO, wr_en plus rd_en same cycle -> read accepted, write rejected, level 255, overflow=1; clr_err -> overflow=0 next cycle.
REQ-034 Empty FIFO, rd_en=1 one cycle -> underflow=1, rd_data unchanged, level stays 0.
REQ-035 FWFT=1: single write of 0x12345678 into empty -> rd_empty=0 and rd_data=0x12345678 one cycle later; continuous pop of 10 streamed words -> one word per cycle, no bubble.
REQ-036 Stream 1000 words with random wr_en/rd_en (DEPTH_WIDTH=4) -> in-order data across pointer wrap, level never exceeds 16, no flag errors.
REQ-037 Assert rst with level 100 mid-stream -> all outputs at reset values immediately; subsequent 5 writes read back correctly.

Source files
------------

// File: rtl/udp_csum_pkg.sv
// rtl/udp_csum_pkg.sv - shared defaults and helpers for the udp_csum FIFO blocks
package udp_csum_pkg;

  localparam int UDP_CSUM_DATA_WIDTH       = 32;
  localparam int UDP_CSUM_DEPTH_WIDTH      = 8;
  localparam int UDP_CSUM_FWFT             = 0;
  localparam int UDP_CSUM_ALMOST_FULL_NUM  = 250;
  localparam int UDP_CSUM_ALMOST_EMPTY_NUM = 4;

  function automatic int unsigned fifo_depth(input int unsigned depth_width);
    return 32'd1 << depth_width;
  endfunction

endpackage

// File: rtl/udp_csum_fifo_ram.sv
// rtl/udp_csum_fifo_ram.sv - simple dual-port storage with one registered read port
module udp_csum_fifo_ram
  import udp_csum_pkg::*;
#(
  parameter int DATA_WIDTH = UDP_CSUM_DATA_WIDTH,
  parameter int ADDR_WIDTH = UDP_CSUM_DEPTH_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [0:(1<<ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Output register holds its value between accepted reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/udp_csum_sync_fifo.sv
// rtl/udp_csum_sync_fifo.sv - single-clock FIFO with level, almost flags, sticky errors
// and optional first-word-fall-through prefetch.
module udp_csum_sync_fifo
  import udp_csum_pkg::*;
#(
  parameter int DATA_WIDTH       = UDP_CSUM_DATA_WIDTH,
  parameter int DEPTH_WIDTH      = UDP_CSUM_DEPTH_WIDTH,
  parameter int FWFT             = UDP_CSUM_FWFT,
  parameter int ALMOST_FULL_NUM  = UDP_CSUM_ALMOST_FULL_NUM,
  parameter int ALMOST_EMPTY_NUM = UDP_CSUM_ALMOST_EMPTY_NUM
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  output logic                   wr_full,
  output logic                   almost_full,
  output logic [DEPTH_WIDTH:0]   wr_water_level,
  input  logic                   rd_en,
  output logic [DATA_WIDTH-1:0]  rd_data,
  output logic                   rd_empty,
  output logic                   almost_empty,
  output logic [DEPTH_WIDTH:0]   rd_water_level,
  output logic                   overflow,
  output logic                   underflow,
  input  logic                   clr_err
);

  localparam int unsigned            DEPTH      = fifo_depth(DEPTH_WIDTH);
  localparam logic [DEPTH_WIDTH:0]   LEVEL_FULL = (DEPTH_WIDTH+1)'(DEPTH);

  logic [DEPTH_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_WIDTH:0]   level_q, level_d;
  logic                   out_valid_q, out_valid_d;
  logic                   overflow_q, overflow_d;
  logic                   underflow_q, underflow_d;
  logic                   wr_accept, rd_accept, ram_rd_en, ram_has_data;

  assign wr_full        = (level_q == LEVEL_FULL);
  assign rd_empty       = (FWFT != 0) ? !out_valid_q : (level_q == '0);
  assign almost_full    = (int'(level_q) >= ALMOST_FULL_NUM);
  assign almost_empty   = (int'(level_q) <= ALMOST_EMPTY_NUM);
  assign wr_water_level = level_q;
  assign rd_water_level = level_q;
  assign overflow       = overflow_q;
  assign underflow      = underflow_q;

  // Level includes the prefetched word, so RAM still holds unread words when level exceeds it.
  assign ram_has_data = (level_q > {{DEPTH_WIDTH{1'b0}}, out_valid_q});

  always_comb begin
    wr_accept   = wr_en && !wr_full;
    rd_accept   = rd_en && !rd_empty;
    ram_rd_en   = rd_accept;
    out_valid_d = 1'b0;
    if (FWFT != 0) begin
      ram_rd_en   = ram_has_data && (!out_valid_q || rd_accept);
      out_valid_d = ram_rd_en || (out_valid_q && !rd_accept);
    end
    wr_ptr_d    = wr_accept ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d    = ram_rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d     = level_q + (DEPTH_WIDTH+1)'(wr_accept) - (DEPTH_WIDTH+1)'(rd_accept);
    overflow_d  = (wr_en && wr_full) || (overflow_q && !clr_err);
    underflow_d = (rd_en && rd_empty) || (underflow_q && !clr_err);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  udp_csum_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (DEPTH_WIDTH)
  ) u_ram (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_accept),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (wr_data),
    .rd_en_i   (ram_rd_en),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (rd_data)
  );

endmodule

// File: tb/tb_udp_csum_sync_fifo.sv
// tb/tb_udp_csum_sync_fifo.sv - directed and random-stream bench for udp_csum_sync_fifo
module tb_udp_csum_sync_fifo;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance a: defaults, standard read.
  logic        a_wr_en, a_rd_en, a_clr;
  logic [31:0] a_wr_data, a_rd_data;
  logic        a_full, a_afull, a_empty, a_aempty, a_ovf, a_unf;
  logic [8:0]  a_wlvl, a_rlvl;

  // Instance b: FWFT, depth 16.
  logic        b_wr_en, b_rd_en, b_clr;
  logic [31:0] b_wr_data, b_rd_data;
  logic        b_full, b_afull, b_empty, b_aempty, b_ovf, b_unf;
  logic [4:0]  b_wlvl, b_rlvl;

  int n_checks = 0;
  int n_fail   = 0;

  udp_csum_sync_fifo u_a (
    .clk(clk), .rst(rst),
    .wr_en(a_wr_en), .wr_data(a_wr_data), .wr_full(a_full), .almost_full(a_afull),
    .wr_water_level(a_wlvl), .rd_en(a_rd_en), .rd_data(a_rd_data), .rd_empty(a_empty),
    .almost_empty(a_aempty), .rd_water_level(a_rlvl), .overflow(a_ovf), .underflow(a_unf),
    .clr_err(a_clr)
  );

  udp_csum_sync_fifo #(
    .DATA_WIDTH(32), .DEPTH_WIDTH(4), .FWFT(1), .ALMOST_FULL_NUM(12), .ALMOST_EMPTY_NUM(2)
  ) u_b (
    .clk(clk), .rst(rst),
    .wr_en(b_wr_en), .wr_data(b_wr_data), .wr_full(b_full), .almost_full(b_afull),
    .wr_water_level(b_wlvl), .rd_en(b_rd_en), .rd_data(b_rd_data), .rd_empty(b_empty),
    .almost_empty(b_aempty), .rd_water_level(b_rlvl), .overflow(b_ovf), .underflow(b_unf),
    .clr_err(b_clr)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    a_wr_en = 0; a_rd_en = 0; a_clr = 0; a_wr_data = '0;
    b_wr_en = 0; b_rd_en = 0; b_clr = 0; b_wr_data = '0;
    rst = 1;
    repeat (2) tick;
    n_checks++;
    if (a_wlvl !== 9'd0 || a_rlvl !== 9'd0) begin
      n_fail++; $display("FAIL reset_level: got %0d/%0d expected 0", a_wlvl, a_rlvl);
    end
    n_checks++;
    if ({a_full, a_afull, a_empty, a_aempty, a_ovf, a_unf} !== 6'b001100) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 001100",
                         {a_full, a_afull, a_empty, a_aempty, a_ovf, a_unf});
    end
    n_checks++;
    if (a_rd_data !== 32'd0 || b_rd_data !== 32'd0) begin
      n_fail++; $display("FAIL reset_rd_data: got %h/%h expected 0", a_rd_data, b_rd_data);
    end
    n_checks++;
    if (b_empty !== 1'b1 || b_wlvl !== 5'd0) begin
      n_fail++; $display("FAIL reset_fwft: got empty=%b level=%0d expected 1/0", b_empty, b_wlvl);
    end
  endtask

  task automatic test_fill_drain;
    logic [31:0] exp;
    rst = 0;
    a_wr_en = 1;
    for (int i = 0; i < 256; i++) begin
      a_wr_data = 32'hFFFF_FFFF - 32'(i);
      tick;
      n_checks++;
      if (a_wlvl !== 9'(i + 1) || a_rlvl !== 9'(i + 1)) begin
        n_fail++; $display("FAIL fill_level[%0d]: got %0d/%0d expected %0d", i, a_wlvl, a_rlvl, i + 1);
      end
      n_checks++;
      if (a_afull !== (i + 1 >= 250) || a_full !== (i == 255)) begin
        n_fail++; $display("FAIL fill_flags[%0d]: got afull=%b full=%b expected %b/%b",
                           i, a_afull, a_full, (i + 1 >= 250), (i == 255));
      end
    end
    a_wr_en = 0;
    a_rd_en = 1;
    for (int i = 0; i < 256; i++) begin
      exp = 32'hFFFF_FFFF - 32'(i);
      tick;
      n_checks++;
      if (a_rd_data !== exp) begin
        n_fail++; $display("FAIL drain_data[%0d]: got %h expected %h", i, a_rd_data, exp);
      end
      n_checks++;
      if (a_wlvl !== 9'(255 - i) || a_empty !== (i == 255) || a_aempty !== (255 - i <= 4)) begin
        n_fail++; $display("FAIL drain_state[%0d]: got level=%0d empty=%b aempty=%b expected %0d",
                           i, a_wlvl, a_empty, a_aempty, 255 - i);
      end
    end
    a_rd_en = 0;
  endtask

  task automatic test_full_rw;
    a_wr_en = 1;
    for (int i = 0; i < 256; i++) begin
      a_wr_data = 32'(i);
      tick;
    end
    n_checks++;
    if (a_full !== 1'b1) begin
      n_fail++; $display("FAIL full_before_rw: got %b expected 1", a_full);
    end
    a_wr_data = 32'hDEAD_BEEF;
    a_rd_en = 1;
    tick;
    a_wr_en = 0; a_rd_en = 0;
    n_checks++;
    if (a_wlvl !== 9'd255 || a_ovf !== 1'b1 || a_full !== 1'b0) begin
      n_fail++; $display("FAIL full_rw_state: got level=%0d ovf=%b full=%b expected 255/1/0",
                         a_wlvl, a_ovf, a_full);
    end
    n_checks++;
    if (a_rd_data !== 32'd0) begin
      n_fail++; $display("FAIL full_rw_data: got %h expected 0", a_rd_data);
    end
    a_clr = 1;
    tick;
    a_clr = 0;
    n_checks++;
    if (a_ovf !== 1'b0) begin
      n_fail++; $display("FAIL clr_overflow: got %b expected 0", a_ovf);
    end
    a_rd_en = 1;
    for (int i = 1; i < 256; i++) begin
      tick;
      n_checks++;
      if (a_rd_data !== 32'(i)) begin
        n_fail++; $display("FAIL full_rw_drain[%0d]: got %h expected %h", i, a_rd_data, 32'(i));
      end
    end
    a_rd_en = 0;
    n_checks++;
    if (a_empty !== 1'b1 || a_wlvl !== 9'd0) begin
      n_fail++; $display("FAIL full_rw_empty: got empty=%b level=%0d expected 1/0", a_empty, a_wlvl);
    end
  endtask

  task automatic test_underflow;
    a_rd_en = 1;
    tick;
    a_rd_en = 0;
    n_checks++;
    if (a_unf !== 1'b1 || a_rd_data !== 32'd255 || a_wlvl !== 9'd0) begin
      n_fail++; $display("FAIL underflow: got unf=%b data=%h level=%0d expected 1/000000ff/0",
                         a_unf, a_rd_data, a_wlvl);
    end
    a_rd_en = 1; a_clr = 1;
    tick;
    a_rd_en = 0; a_clr = 0;
    n_checks++;
    if (a_unf !== 1'b1) begin
      n_fail++; $display("FAIL underflow_priority: got %b expected 1", a_unf);
    end
    tick;
    n_checks++;
    if (a_unf !== 1'b1 || a_ovf !== 1'b0) begin
      n_fail++; $display("FAIL underflow_sticky: got unf=%b ovf=%b expected 1/0", a_unf, a_ovf);
    end
    a_clr = 1;
    tick;
    a_clr = 0;
    n_checks++;
    if (a_unf !== 1'b0) begin
      n_fail++; $display("FAIL underflow_clear: got %b expected 0", a_unf);
    end
  endtask

  task automatic test_fwft;
    b_wr_en = 1; b_wr_data = 32'h1234_5678;
    tick;
    b_wr_en = 0;
    n_checks++;
    if (b_wlvl !== 5'd1 || b_empty !== 1'b1) begin
      n_fail++; $display("FAIL fwft_write_edge: got level=%0d empty=%b expected 1/1", b_wlvl, b_empty);
    end
    tick;
    n_checks++;
    if (b_empty !== 1'b0 || b_rd_data !== 32'h1234_5678 || b_rlvl !== 5'd1) begin
      n_fail++; $display("FAIL fwft_first_word: got empty=%b data=%h level=%0d expected 0/12345678/1",
                         b_empty, b_rd_data, b_rlvl);
    end
    b_rd_en = 1;
    tick;
    b_rd_en = 0;
    n_checks++;
    if (b_empty !== 1'b1 || b_wlvl !== 5'd0 || b_unf !== 1'b0) begin
      n_fail++; $display("FAIL fwft_pop_single: got empty=%b level=%0d unf=%b expected 1/0/0",
                         b_empty, b_wlvl, b_unf);
    end
    b_wr_en = 1;
    for (int i = 0; i < 10; i++) begin
      b_wr_data = 32'hA000_0000 + 32'(i);
      tick;
    end
    b_wr_en = 0;
    n_checks++;
    if (b_wlvl !== 5'd10 || b_empty !== 1'b0 || b_rd_data !== 32'hA000_0000) begin
      n_fail++; $display("FAIL fwft_prefill: got level=%0d empty=%b data=%h expected 10/0/a0000000",
                         b_wlvl, b_empty, b_rd_data);
    end
    b_rd_en = 1;
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (b_empty !== 1'b0 || b_rd_data !== 32'hA000_0000 + 32'(i)) begin
        n_fail++; $display("FAIL fwft_stream[%0d]: got empty=%b data=%h expected 0/%h",
                           i, b_empty, b_rd_data, 32'hA000_0000 + 32'(i));
      end
      tick;
    end
    b_rd_en = 0;
    n_checks++;
    if (b_empty !== 1'b1 || b_wlvl !== 5'd0) begin
      n_fail++; $display("FAIL fwft_stream_end: got empty=%b level=%0d expected 1/0", b_empty, b_wlvl);
    end
  endtask

  task automatic test_stream;
    logic [31:0] q[$];
    logic [31:0] d;
    logic        we, re, wacc, racc, ovf_m;
    int          written = 0;
    int          cycles  = 0;
    int          sz;
    ovf_m = 1'b0;
    while ((written < 1000 || q.size() != 0) && cycles < 20000) begin
      we   = (written < 1000) && 1'($urandom_range(0, 1));
      re   = 1'($urandom_range(0, 1));
      d    = $urandom;
      wacc = we && (q.size() < 16);
      racc = re && !b_empty;
      ovf_m = ovf_m || (we && q.size() == 16);
      b_wr_en = we; b_wr_data = d; b_rd_en = re;
      tick;
      cycles++;
      if (racc) void'(q.pop_front());
      if (wacc) begin
        q.push_back(d);
        written++;
      end
      sz = q.size();
      n_checks++;
      if (b_wlvl !== 5'(sz) || b_rlvl !== 5'(sz) || b_wlvl > 5'd16) begin
        n_fail++; $display("FAIL stream_level[%0d]: got %0d/%0d expected %0d", cycles, b_wlvl, b_rlvl, sz);
      end
      n_checks++;
      if ({b_full, b_afull, b_aempty, b_ovf} !== {sz == 16, sz >= 12, sz <= 2, ovf_m}) begin
        n_fail++; $display("FAIL stream_flags[%0d]: got %b expected %b", cycles,
                           {b_full, b_afull, b_aempty, b_ovf}, {sz == 16, sz >= 12, sz <= 2, ovf_m});
      end
      if (sz == 0) begin
        n_checks++;
        if (b_empty !== 1'b1) begin
          n_fail++; $display("FAIL stream_empty[%0d]: got %b expected 1", cycles, b_empty);
        end
      end
      if (!b_empty) begin
        n_checks++;
        if (sz == 0 || b_rd_data !== q[0]) begin
          n_fail++; $display("FAIL stream_data[%0d]: got %h expected %h", cycles, b_rd_data,
                             (sz == 0) ? 32'hx : q[0]);
        end
      end
    end
    b_wr_en = 0; b_rd_en = 0;
    n_checks++;
    if (written != 1000 || q.size() != 0) begin
      n_fail++; $display("FAIL stream_timeout: got written=%0d left=%0d expected 1000/0", written, q.size());
    end
  endtask

  task automatic test_reset_mid;
    a_wr_en = 1;
    for (int i = 0; i < 100; i++) begin
      a_wr_data = 32'h1000 + 32'(i);
      tick;
    end
    n_checks++;
    if (a_wlvl !== 9'd100) begin
      n_fail++; $display("FAIL mid_level: got %0d expected 100", a_wlvl);
    end
    #2 rst = 1;
    #1;
    n_checks++;
    if (a_wlvl !== 9'd0 || a_rlvl !== 9'd0 || a_rd_data !== 32'd0) begin
      n_fail++; $display("FAIL mid_reset_level_data: got %0d/%0d/%h expected 0/0/0", a_wlvl, a_rlvl, a_rd_data);
    end
    n_checks++;
    if ({a_full, a_afull, a_empty, a_aempty, a_ovf, a_unf} !== 6'b001100) begin
      n_fail++; $display("FAIL mid_reset_flags: got %b expected 001100",
                         {a_full, a_afull, a_empty, a_aempty, a_ovf, a_unf});
    end
    a_wr_data = 32'h5000;
    tick;
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      a_wr_data = 32'h5000 + 32'(i);
      tick;
      n_checks++;
      if (a_wlvl !== 9'(i + 1)) begin
        n_fail++; $display("FAIL post_reset_level[%0d]: got %0d expected %0d", i, a_wlvl, i + 1);
      end
    end
    a_wr_en = 0;
    a_rd_en = 1;
    for (int i = 0; i < 5; i++) begin
      tick;
      n_checks++;
      if (a_rd_data !== 32'h5000 + 32'(i)) begin
        n_fail++; $display("FAIL post_reset_data[%0d]: got %h expected %h", i, a_rd_data, 32'h5000 + 32'(i));
      end
    end
    a_rd_en = 0;
    n_checks++;
    if (a_empty !== 1'b1 || a_wlvl !== 9'd0) begin
      n_fail++; $display("FAIL post_reset_empty: got empty=%b level=%0d expected 1/0", a_empty, a_wlvl);
    end
  endtask

  initial begin
    test_reset;
    test_fill_drain;
    test_full_rw;
    test_underflow;
    test_fwft;
    test_stream;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
